mean_restore: RTL and testbench

MEAN_RESTORE -- requirements
Module: mean_restore

---
 rtl/mean_restore_if.sv | 21 ++
 rtl/mean_restore.sv | 103 ++++++++++
 tb/tb_mean_restore.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mean_restore_if.sv
// rtl/mean_restore_if.sv - sample-in / pixel-out stream bundle for mean_restore
interface mean_restore_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  // slave is the mean_restore side; master is the producer/consumer around it
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mean_restore.sv
// rtl/mean_restore.sv - adds a window mean back onto mean-subtracted samples,
// saturating to 8 bits and checking the restored window mean against avg_in.
module mean_restore #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          avg_in,
  mean_restore_if.slave       s,
  output logic                busy,
  output logic                done,
  output logic                clamp_err,
  output logic                sum_mismatch
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [WIN_LOG2-1:0] LAST_CNT = '1;

  logic [1:0]            state;
  logic [7:0]            avg;
  logic [WIN_LOG2-1:0]   cnt;
  logic [WIN_LOG2+7:0]   sum;
  logic signed [9:0]     r;
  logic [7:0]            pix;
  logic                  sat;
  logic                  accept;
  logic                  out_hs;

  // 10-bit signed sum cannot overflow for any 9-bit sample plus 8-bit mean
  assign r   = $signed({s.in_data[8], s.in_data}) + $signed({2'b00, avg});
  assign sat = r[9] | r[8];
  assign pix = r[9] ? 8'h00 : (r[8] ? 8'hFF : r[7:0]);

  assign s.in_ready = (state == STREAM) && (!s.out_valid || s.out_ready);
  assign accept     = s.in_valid && s.in_ready;
  assign out_hs     = s.out_valid && s.out_ready;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      avg          <= '0;
      cnt          <= '0;
      sum          <= '0;
      clamp_err    <= 1'b0;
      sum_mismatch <= 1'b0;
      s.out_valid  <= 1'b0;
      s.out_data   <= '0;
      s.out_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= STREAM;
            avg          <= avg_in;
            cnt          <= '0;
            sum          <= '0;
            clamp_err    <= 1'b0;
            sum_mismatch <= 1'b0;
          end
        end
        STREAM: begin
          if (accept) begin
            s.out_valid <= 1'b1;
            s.out_data  <= pix;
            s.out_last  <= (cnt == LAST_CNT);
            sum         <= sum + {{WIN_LOG2{1'b0}}, pix};
            if (sat) clamp_err <= 1'b1;
            // counter parks at its maximum so it never wraps inside a window
            if (cnt == LAST_CNT) state <= FLUSH;
            else cnt <= cnt + 1'b1;
          end else if (out_hs) begin
            s.out_valid <= 1'b0;
            s.out_last  <= 1'b0;
          end
        end
        FLUSH: begin
          if (out_hs) begin
            s.out_valid <= 1'b0;
            s.out_last  <= 1'b0;
            if (s.out_last) begin
              state        <= DONE;
              sum_mismatch <= (sum[WIN_LOG2+7:WIN_LOG2] != avg);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mean_restore.sv
// tb/tb_mean_restore.sv - randomized bench for mean_restore with a cycle model
// and an end-of-window pixel scoreboard.
module tb_mean_restore;
  localparam int W = 8;
  localparam int N = 1 << W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] avg_in = 8'd0;
  logic       busy, done, clamp_err, sum_mismatch;

  mean_restore_if px();

  mean_restore #(.WIN_LOG2(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .avg_in       (avg_in),
    .s            (px),
    .busy         (busy),
    .done         (done),
    .clamp_err    (clamp_err),
    .sum_mismatch (sum_mismatch)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int samp [N];
  int got_q [$];
  int done_cyc;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int signed_val(input int d9);
    return (d9 >= 256) ? d9 - 512 : d9;
  endfunction

  function automatic int restore(input int d9, input int a);
    int v;
    v = signed_val(d9) + a;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic bit saturates(input int d9, input int a);
    int v;
    v = signed_val(d9) + a;
    return (v < 0) || (v > 255);
  endfunction

  // reference model: phase 0 idle, 1 taking samples, 2 draining last pixel, 3 done
  int m_phase = 0, m_avg = 0, m_cnt = 0, m_sum = 0, m_data = 0;
  bit m_v = 0, m_last = 0, m_clamp = 0, m_mis = 0;
  bit prev_stall = 0;
  int prev_data = 0;

  always @(negedge clk) begin
    bit ir, acc, hs;
    ir  = (m_phase == 1) && (!m_v || px.out_ready);
    acc = px.in_valid && ir;
    hs  = m_v && px.out_ready;
    if (chk_en) begin
      chk("out_valid", px.out_valid, m_v);
      if (m_v) begin
        chk("out_data", px.out_data, m_data);
        chk("out_last", px.out_last, m_last);
      end
      chk("in_ready", px.in_ready, ir);
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 3);
      chk("clamp_err", clamp_err, m_clamp);
      chk("sum_mismatch", sum_mismatch, m_mis);
      if (prev_stall) chk("stall_hold", px.out_data, prev_data);
      if (px.out_valid && px.out_ready && !rst) got_q.push_back(int'(px.out_data));
    end
    prev_stall = px.out_valid && !px.out_ready && !rst;
    prev_data  = px.out_data;

    if (rst) begin
      m_phase = 0; m_avg = 0; m_cnt = 0; m_sum = 0; m_data = 0;
      m_v = 0; m_last = 0; m_clamp = 0; m_mis = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_avg = avg_in; m_cnt = 0; m_sum = 0; m_clamp = 0; m_mis = 0;
        end
        1: if (acc) begin
          m_data  = restore(px.in_data, m_avg);
          m_clamp = m_clamp | saturates(px.in_data, m_avg);
          m_sum  += m_data;
          m_v     = 1;
          m_cnt++;
          m_last  = (m_cnt == N);
          if (m_cnt == N) m_phase = 2;
        end else if (hs) begin
          m_v = 0; m_last = 0;
        end
        2: if (hs) begin
          m_v = 0;
          if (m_last) begin
            m_phase = 3;
            m_mis = ((m_sum / N) != m_avg);
          end
          m_last = 0;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic run_window(input int a, input int stall_pct, input int valid_pct,
                            input int abort_after, input bit poke);
    int idx;
    bit fin;
    idx = 0;
    fin = 0;
    done_cyc = -1;
    got_q.delete();
    start  = 1'b1;
    avg_in = 8'(a);
    @(posedge clk); #1;
    start  = 1'b0;
    avg_in = 8'($urandom_range(0, 255));
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      px.in_valid  = (idx < N) && ($urandom_range(0, 99) < valid_pct);
      px.in_data   = px.in_valid ? 9'(samp[idx]) : 9'($urandom);
      px.out_ready = ($urandom_range(0, 99) >= stall_pct);
      if (poke && idx == 50) begin
        start  = 1'b1;
        avg_in = 8'(a) ^ 8'h5a;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (px.in_valid && px.in_ready) idx++;
      if (done) begin
        fin = 1;
        done_cyc = cyc;
      end
      @(posedge clk); #1;
      if (abort_after > 0 && idx == abort_after) begin
        rst = 1'b1;
        start = 1'b1;
        px.in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        px.in_valid = 1'b0;
        chk("rst_out_valid", px.out_valid, 0);
        chk("rst_out_data", px.out_data, 0);
        chk("rst_out_last", px.out_last, 0);
        chk("rst_in_ready", px.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {clamp_err, sum_mismatch}, 0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_done", done, 0);
        end
        @(posedge clk); #1;
        return;
      end
    end
    px.in_valid = 1'b0;
    start = 1'b0;
    chk("window_completed", fin, 1);
    chk("pixel_count", got_q.size(), N);
    if (got_q.size() == N) begin
      for (int i = 0; i < N; i++) chk("pixel_value", got_q[i], restore(samp[i], a));
    end
  endtask

  initial begin
    px.in_valid  = 1'b0;
    px.in_data   = '0;
    px.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", px.out_valid, 0);
    chk("reset_out_data", px.out_data, 0);
    chk("reset_in_ready", px.in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_flags", {done, clamp_err, sum_mismatch}, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // all-zero samples around a mean of 100 at full throughput
    for (int i = 0; i < N; i++) samp[i] = 0;
    run_window(100, 0, 100, 0, 0);
    chk("t1_first_pix", got_q.size() > 0 ? got_q[0] : -1, 100);
    chk("t1_last_pix", got_q.size() > 0 ? got_q[got_q.size()-1] : -1, 100);
    chk("t1_done_cycle", done_cyc, 257);
    chk("t1_flags", {clamp_err, sum_mismatch}, 0);

    // high and low saturation
    samp[0] = 100;
    run_window(200, 0, 100, 0, 0);
    chk("t2_hi_pix", got_q.size() > 0 ? got_q[0] : -1, 255);
    chk("t2_hi_clamp", clamp_err, 1);
    samp[0] = 'h1CE;
    run_window(10, 0, 100, 0, 0);
    chk("t2_lo_pix", got_q.size() > 0 ? got_q[0] : -1, 0);
    chk("t2_lo_clamp", clamp_err, 1);

    // ramp 0..255 subtracted about 127
    for (int p = 0; p < N; p++) samp[p] = (p - 127) & 511;
    run_window(127, 0, 100, 0, 0);
    chk("t3_pix200", got_q.size() > 200 ? got_q[200] : -1, 200);
    chk("t3_mis127", sum_mismatch, 0);
    chk("t3_clamp127", clamp_err, 0);
    // restored p-7 floored at 0 sums to 30876, whose /256 is 120
    run_window(120, 0, 100, 0, 0);
    chk("t3_mis120", sum_mismatch, 0);
    chk("t3_clamp120", clamp_err, 1);
    // restored p-27 floored at 0 sums to 26106, whose /256 is 101
    run_window(100, 0, 100, 0, 0);
    chk("t3_mis100", sum_mismatch, 1);

    // random data with 30% downstream stalls and sparse input
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) samp[i] = $urandom_range(0, 511);
      run_window($urandom_range(0, 255), 30, 70, 0, 0);
    end

    // mid-window reset, then a clean window
    for (int i = 0; i < N; i++) samp[i] = $urandom_range(0, 511);
    run_window(77, 20, 80, 37, 0);
    run_window(77, 0, 100, 0, 0);
    chk("t5_clean_done_cycle", done_cyc, 257);

    // start re-pulsed mid-stream with a different mean must be ignored
    for (int i = 0; i < N; i++) samp[i] = $urandom_range(0, 511);
    run_window(60, 30, 90, 0, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
